jtag_tap_ctrl: RTL and testbench

- IEEE 1149.1 TAP controller plus 2-bit instruction register for the s9234 JTAG wrapper.
- Sits upstream of the boundary-scan register (BSR) and the internal scan register (ISR).
- Decodes TMS into per-state strobes, holds and decodes the active instruction, owns the 1-bit bypass register, and muxes the selected serial output onto TDO.

---
 rtl/jtag_pkg.sv | 30 +++
 rtl/jtag_tap_fsm.sv | 58 +++++
 rtl/jtag_tap_ctrl.sv | 109 ++++++++++
 tb/tb_jtag_tap_ctrl.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/jtag_pkg.sv
// Shared TAP state encodings, instruction opcodes and IR width for the s9234 JTAG wrapper.
package jtag_pkg;

    localparam int IR_W = 2;

    typedef enum logic [3:0] {
        S_TLR     = 4'hF,
        S_RTI     = 4'hC,
        S_SELDR   = 4'h7,
        S_CAPDR   = 4'h6,
        S_SHDR    = 4'h2,
        S_EX1DR   = 4'h1,
        S_PAUSEDR = 4'h3,
        S_EX2DR   = 4'h0,
        S_UPDR    = 4'h5,
        S_SELIR   = 4'h4,
        S_CAPIR   = 4'hE,
        S_SHIR    = 4'hA,
        S_EX1IR   = 4'h9,
        S_PAUSEIR = 4'hB,
        S_EX2IR   = 4'h8,
        S_UPIR    = 4'hD
    } tap_state_t;

    localparam logic [IR_W-1:0] IR_EXTEST  = 2'b00;
    localparam logic [IR_W-1:0] IR_SAMPLE  = 2'b01;
    localparam logic [IR_W-1:0] IR_INTSCAN = 2'b10;
    localparam logic [IR_W-1:0] IR_BYPASS  = 2'b11;

endpackage

// File: rtl/jtag_tap_fsm.sv
// 16-state IEEE 1149.1 TAP state machine with Moore state-decode strobes.
module jtag_tap_fsm
    import jtag_pkg::*;
(
    input  logic       i_tclk,
    input  logic       i_trst_n,
    input  logic       i_tms,
    output tap_state_t o_state,
    output logic       o_tlr_next,
    output logic       o_capture_dr,
    output logic       o_shift_dr,
    output logic       o_update_dr,
    output logic       o_capture_ir,
    output logic       o_shift_ir,
    output logic       o_update_ir
);

    tap_state_t r_state;
    tap_state_t w_next;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_TLR:     w_next = i_tms ? S_TLR   : S_RTI;
            S_RTI:     w_next = i_tms ? S_SELDR : S_RTI;
            S_SELDR:   w_next = i_tms ? S_SELIR : S_CAPDR;
            S_CAPDR:   w_next = i_tms ? S_EX1DR : S_SHDR;
            S_SHDR:    w_next = i_tms ? S_EX1DR : S_SHDR;
            S_EX1DR:   w_next = i_tms ? S_UPDR  : S_PAUSEDR;
            S_PAUSEDR: w_next = i_tms ? S_EX2DR : S_PAUSEDR;
            S_EX2DR:   w_next = i_tms ? S_UPDR  : S_SHDR;
            S_UPDR:    w_next = i_tms ? S_SELDR : S_RTI;
            S_SELIR:   w_next = i_tms ? S_TLR   : S_CAPIR;
            S_CAPIR:   w_next = i_tms ? S_EX1IR : S_SHIR;
            S_SHIR:    w_next = i_tms ? S_EX1IR : S_SHIR;
            S_EX1IR:   w_next = i_tms ? S_UPIR  : S_PAUSEIR;
            S_PAUSEIR: w_next = i_tms ? S_EX2IR : S_PAUSEIR;
            S_EX2IR:   w_next = i_tms ? S_UPIR  : S_SHIR;
            S_UPIR:    w_next = i_tms ? S_SELDR : S_RTI;
            default:   w_next = S_TLR;
        endcase
    end

    always_ff @(posedge i_tclk or negedge i_trst_n) begin
        if (!i_trst_n) r_state <= S_TLR;
        else           r_state <= w_next;
    end

    assign o_state      = r_state;
    assign o_tlr_next   = (w_next == S_TLR);
    assign o_capture_dr = (r_state == S_CAPDR);
    assign o_shift_dr   = (r_state == S_SHDR);
    assign o_update_dr  = (r_state == S_UPDR);
    assign o_capture_ir = (r_state == S_CAPIR);
    assign o_shift_ir   = (r_state == S_SHIR);
    assign o_update_ir  = (r_state == S_UPIR);

endmodule

// File: rtl/jtag_tap_ctrl.sv
// TAP controller top: IR, instruction decode, bypass bit and TDO mux.
// Define TAP_TDO_NEGEDGE_EN to retime TDO/tdo_en onto falling TCLK.
module jtag_tap_ctrl #(
    parameter int                    IR_W       = jtag_pkg::IR_W,
    parameter logic [IR_W-1:0]       IR_CAPTURE = 2'b01,
    parameter logic [IR_W-1:0]       IR_RESET   = 2'b11
) (
    input  logic            TCLK,
    input  logic            TRST,
    input  logic            TMS,
    input  logic            TDI,
    input  logic            bsr_so,
    input  logic            isr_so,
    output logic            TDO,
    output logic            tdo_en,
    output logic            capture_dr,
    output logic            shift_dr,
    output logic            update_dr,
    output logic            sel_bsr,
    output logic            sel_isr,
    output logic            bsr_mode,
    output logic [IR_W-1:0] inst,
    output logic [3:0]      tap_state
);
    import jtag_pkg::*;

    tap_state_t      w_state;
    logic            w_tlr_next;
    logic            w_cap_dr, w_sh_dr, w_up_dr;
    logic            w_cap_ir, w_sh_ir, w_up_ir;
    logic            w_dr_sel;
    logic            w_tdo;
    logic            w_tdo_en;
    logic [IR_W-1:0] r_ir_shift;
    logic [IR_W-1:0] r_inst;
    logic            r_bypass;

    jtag_tap_fsm u_fsm (
        .i_tclk       (TCLK),
        .i_trst_n     (TRST),
        .i_tms        (TMS),
        .o_state      (w_state),
        .o_tlr_next   (w_tlr_next),
        .o_capture_dr (w_cap_dr),
        .o_shift_dr   (w_sh_dr),
        .o_update_dr  (w_up_dr),
        .o_capture_ir (w_cap_ir),
        .o_shift_ir   (w_sh_ir),
        .o_update_ir  (w_up_ir)
    );

    // Falling into TLR overrides any pending UPIR load.
    always_ff @(posedge TCLK or negedge TRST) begin
        if (!TRST) begin
            r_ir_shift <= '0;
            r_inst     <= IR_RESET;
            r_bypass   <= 1'b0;
        end else begin
            if (w_cap_ir)     r_ir_shift <= IR_CAPTURE;
            else if (w_sh_ir) r_ir_shift <= {TDI, r_ir_shift[IR_W-1:1]};

            if (w_tlr_next)   r_inst <= IR_RESET;
            else if (w_up_ir) r_inst <= r_ir_shift;

            if (w_cap_dr)                           r_bypass <= 1'b0;
            else if (w_sh_dr && r_inst == IR_BYPASS) r_bypass <= TDI;
        end
    end

    assign inst      = r_inst;
    assign tap_state = w_state;
    assign sel_bsr   = (r_inst == IR_EXTEST) || (r_inst == IR_SAMPLE);
    assign sel_isr   = (r_inst == IR_INTSCAN);
    assign bsr_mode  = (r_inst == IR_EXTEST);
    assign w_dr_sel  = sel_bsr || sel_isr;

    assign capture_dr = w_cap_dr && w_dr_sel;
    assign shift_dr   = w_sh_dr  && w_dr_sel;
    assign update_dr  = w_up_dr  && w_dr_sel;

    always_comb begin
        w_tdo    = 1'b0;
        w_tdo_en = w_sh_dr || w_sh_ir;
        if (w_sh_ir)      w_tdo = r_ir_shift[0];
        else if (w_sh_dr) w_tdo = sel_bsr ? bsr_so : (sel_isr ? isr_so : r_bypass);
    end

`ifdef TAP_TDO_NEGEDGE_EN
    logic r_tdo;
    logic r_tdo_en;

    always_ff @(negedge TCLK or negedge TRST) begin
        if (!TRST) begin
            r_tdo    <= 1'b0;
            r_tdo_en <= 1'b0;
        end else begin
            r_tdo    <= w_tdo;
            r_tdo_en <= w_tdo_en;
        end
    end

    assign TDO    = r_tdo;
    assign tdo_en = r_tdo_en;
`else
    assign TDO    = w_tdo;
    assign tdo_en = w_tdo_en;
`endif

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// Directed testbench for jtag_tap_ctrl (default build, combinational TDO).
module tb_jtag_tap_ctrl;

    logic       TCLK = 1'b0;
    logic       TRST = 1'b1;
    logic       TMS = 1'b1;
    logic       TDI = 1'b0;
    logic       bsr_so = 1'b0;
    logic       isr_so = 1'b1;
    logic       TDO, tdo_en;
    logic       capture_dr, shift_dr, update_dr;
    logic       sel_bsr, sel_isr, bsr_mode;
    logic [1:0] inst;
    logic [3:0] tap_state;

    int total = 0;
    int bad = 0;

    jtag_tap_ctrl dut (
        .TCLK       (TCLK),
        .TRST       (TRST),
        .TMS        (TMS),
        .TDI        (TDI),
        .bsr_so     (bsr_so),
        .isr_so     (isr_so),
        .TDO        (TDO),
        .tdo_en     (tdo_en),
        .capture_dr (capture_dr),
        .shift_dr   (shift_dr),
        .update_dr  (update_dr),
        .sel_bsr    (sel_bsr),
        .sel_isr    (sel_isr),
        .bsr_mode   (bsr_mode),
        .inst       (inst),
        .tap_state  (tap_state)
    );

    always #5 TCLK = ~TCLK;

    task automatic tck(input logic tms, input logic tdi);
        TMS = tms;
        TDI = tdi;
        @(posedge TCLK);
        #1;
    endtask

    // Shifts val LSB-first through SHIR and returns to RTI.
    task automatic load_ir(input logic [1:0] val);
        tck(1, 0); tck(1, 0); tck(0, 0); tck(0, 0);
        tck(0, val[0]); tck(1, val[1]);
        tck(1, 0); tck(0, 0);
    endtask

    task automatic test_reset;
        #3 TRST = 1'b0;
        #1;
        total++; if (tap_state !== 4'hF) begin bad++; $display("FAIL reset_state got=%h exp=f", tap_state); end
        total++; if (inst !== 2'b11) begin bad++; $display("FAIL reset_inst got=%b exp=11", inst); end
        total++; if (tdo_en !== 1'b0 || TDO !== 1'b0) begin bad++; $display("FAIL reset_tdo got=%b%b exp=00", tdo_en, TDO); end
        total++; if ({capture_dr, shift_dr, update_dr, sel_bsr, sel_isr} !== 5'b0) begin bad++;
            $display("FAIL reset_strobes got=%b exp=00000", {capture_dr, shift_dr, update_dr, sel_bsr, sel_isr}); end
        @(negedge TCLK);
        TRST = 1'b1;
        tck(1, 0); tck(1, 0); tck(1, 0);
        total++; if (tap_state !== 4'hF) begin bad++; $display("FAIL reset_hold got=%h exp=f", tap_state); end
        tck(0, 0);
        total++; if (tap_state !== 4'hC) begin bad++; $display("FAIL reset_rti got=%h exp=c", tap_state); end
    endtask

    task automatic test_escape;
        int ups;
        ups = 0;
        tck(1, 0); tck(0, 0); tck(0, 0);
        total++; if (tap_state !== 4'h2) begin bad++; $display("FAIL esc_shdr got=%h exp=2", tap_state); end
        for (int i = 0; i < 5; i++) begin
            tck(1, 0);
            if (update_dr) ups++;
        end
        total++; if (tap_state !== 4'hF) begin bad++; $display("FAIL esc_tlr got=%h exp=f", tap_state); end
        total++; if (inst !== 2'b11) begin bad++; $display("FAIL esc_inst got=%b exp=11", inst); end
        total++; if (ups !== 0) begin bad++; $display("FAIL esc_update got=%0d exp=0", ups); end
        tck(0, 0);
    endtask

    task automatic test_bypass;
        logic [7:0] bits;
        bits = 8'b1100_1101;
        tck(1, 0); tck(0, 0);
        total++; if (capture_dr !== 1'b0) begin bad++; $display("FAIL byp_cap got=%b exp=0", capture_dr); end
        tck(0, 0);
        total++; if (TDO !== 1'b0 || tdo_en !== 1'b1) begin bad++; $display("FAIL byp_first got=%b%b exp=10", tdo_en, TDO); end
        for (int k = 0; k < 8; k++) begin
            tck(k == 7, bits[k]);
            if (k < 7) begin
                total++; if (TDO !== bits[k] || shift_dr !== 1'b0) begin bad++;
                    $display("FAIL byp_shift%0d got=%b/%b exp=%b/0", k, TDO, shift_dr, bits[k]); end
            end
        end
        tck(1, 0);
        total++; if (tap_state !== 4'h5 || update_dr !== 1'b0) begin bad++;
            $display("FAIL byp_upd got=%h/%b exp=5/0", tap_state, update_dr); end
        tck(0, 0);
    endtask

    task automatic test_ir_load;
        tck(1, 0); tck(1, 0); tck(0, 0); tck(0, 0);
        total++; if (tap_state !== 4'hA || tdo_en !== 1'b1) begin bad++; $display("FAIL ir_shir got=%h/%b exp=a/1", tap_state, tdo_en); end
        total++; if (TDO !== 1'b1) begin bad++; $display("FAIL ir_tdo0 got=%b exp=1", TDO); end
        tck(0, 0);
        total++; if (TDO !== 1'b0) begin bad++; $display("FAIL ir_tdo1 got=%b exp=0", TDO); end
        tck(1, 1);
        total++; if (tap_state !== 4'h9 || inst !== 2'b11) begin bad++; $display("FAIL ir_ex1 got=%h/%b exp=9/11", tap_state, inst); end
        tck(1, 0);
        tck(0, 0);
        total++; if (inst !== 2'b10 || sel_isr !== 1'b1 || sel_bsr !== 1'b0) begin bad++;
            $display("FAIL ir_inst got=%b/%b%b exp=10/10", inst, sel_isr, sel_bsr); end
    endtask

    task automatic test_extest;
        int n_shift;
        logic exp_so;
        n_shift = 0;
        load_ir(2'b00);
        total++; if (inst !== 2'b00 || sel_bsr !== 1'b1 || bsr_mode !== 1'b1) begin bad++;
            $display("FAIL ext_inst got=%b/%b%b exp=00/11", inst, sel_bsr, bsr_mode); end
        tck(1, 0); tck(0, 0);
        total++; if (capture_dr !== 1'b1) begin bad++; $display("FAIL ext_cap got=%b exp=1", capture_dr); end
        tck(0, 0);
        for (int i = 0; i < 35; i++) begin
            exp_so = (i % 3 == 0);
            bsr_so = exp_so;
            #1;
            if (shift_dr) n_shift++;
            total++; if (TDO !== exp_so) begin bad++; $display("FAIL ext_tdo%0d got=%b exp=%b", i, TDO, exp_so); end
            tck(i == 34, 0);
        end
        total++; if (n_shift !== 35 || shift_dr !== 1'b0) begin bad++;
            $display("FAIL ext_nshift got=%0d/%b exp=35/0", n_shift, shift_dr); end
        tck(1, 0);
        total++; if (update_dr !== 1'b1) begin bad++; $display("FAIL ext_upd got=%b exp=1", update_dr); end
        tck(0, 0);
        total++; if (update_dr !== 1'b0 || tap_state !== 4'hC) begin bad++;
            $display("FAIL ext_rti got=%b/%h exp=0/c", update_dr, tap_state); end
    endtask

    task automatic test_midop_reset;
        tck(1, 0); tck(1, 0); tck(0, 0); tck(0, 0);
        tck(0, 1);
        TMS = 1'b1;
        TDI = 1'b0;
        @(negedge TCLK);
        #3 TRST = 1'b0;
        #1;
        total++; if (tap_state !== 4'hF || inst !== 2'b11) begin bad++;
            $display("FAIL mid_imm got=%h/%b exp=f/11", tap_state, inst); end
        total++; if (dut.r_ir_shift !== 2'b00) begin bad++; $display("FAIL mid_irsh got=%b exp=00", dut.r_ir_shift); end
        @(posedge TCLK); #1;
        @(negedge TCLK);
        TRST = 1'b1;
        tck(1, 0); tck(1, 0);
        total++; if (tap_state !== 4'hF || inst !== 2'b11) begin bad++;
            $display("FAIL mid_noupir got=%h/%b exp=f/11", tap_state, inst); end
    endtask

    initial begin
        test_reset();
        test_escape();
        test_bypass();
        test_ir_load();
        test_extest();
        test_midop_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout got=running exp=done");
        $fatal(1);
    end

endmodule
